// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage load/store front-end: access sizes,
// controller states and the default RAM geometry.
package mem_access_pkg;

    localparam int unsigned ADDR_WIDTH_DEFAULT = 13;
    localparam int unsigned DEPTH_DEFAULT      = 4401;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR      = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

endpackage

// File: rtl/ld_align.sv
// Big-endian lane extraction with sign/zero extension for sub-word loads.
// Purely combinational so the forwarding path can share it.
module ld_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        // Offset 0 is the most significant byte.
        case (offset_i)
            2'd0:    byte_lane = word_i[31:24];
            2'd1:    byte_lane = word_i[23:16];
            2'd2:    byte_lane = word_i[15:8];
            default: byte_lane = word_i[7:0];
        endcase
        half_lane = offset_i[1] ? word_i[15:0] : word_i[31:16];

        case (size_i)
            SZ_BYTE: data_o = {{24{byte_lane[7] & ~unsigned_i}}, byte_lane};
            SZ_HALF: data_o = {{16{half_lane[15] & ~unsigned_i}}, half_lane};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end: byte-addressed requests to a word RAM with a
// one-cycle registered read; sub-word stores are read-modify-write.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int unsigned DEPTH      = DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    input  logic [31:0]           mem_rdata,
    output state_e                dbg_state_o
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [1:0]            size_q;
    logic                  write_q;
    logic                  unsigned_q;
    logic [31:0]           data_q;
    logic [31:0]           resp_rdata_q;
    logic                  resp_err_q;

    logic                  accept;
    logic                  req_err;
    logic [31:0]           ld_data;
    logic [31:0]           merged;

    // Handshake: a request is taken on a rising edge where req_valid and
    // req_ready are both high; req_ready is high only in IDLE, and the
    // request fields are don't-care on every other edge.
    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid & req_ready;

    assign req_err = (req_size == 2'b11)
                   || (req_size == SZ_HALF && req_addr[0])
                   || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                   || (req_addr[31:2] >= 30'(DEPTH));

    ld_align u_ld_align (
        .word_i     (mem_rdata),
        .offset_i   (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .data_o     (ld_data)
    );

    // data_q still holds the right-aligned store data when the read returns.
    always_comb begin
        merged = mem_rdata;
        if (size_q == SZ_BYTE) begin
            case (addr_q[1:0])
                2'd0:    merged[31:24] = data_q[7:0];
                2'd1:    merged[23:16] = data_q[7:0];
                2'd2:    merged[15:8]  = data_q[7:0];
                default: merged[7:0]   = data_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[15:0] = data_q[15:0];
        end else begin
            merged[31:16] = data_q[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)                                state_d = ST_RESP;
                    else if (req_write && req_size == SZ_WORD) state_d = ST_WR;
                    else                                        state_d = ST_RD;
                end
            end
            ST_RD:      state_d = ST_RD_DATA;
            ST_RD_DATA: state_d = write_q ? ST_WR : ST_RESP;
            ST_WR:      state_d = ST_RESP;
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            size_q       <= '0;
            write_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            data_q       <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q     <= req_addr[ADDR_WIDTH+1:0];
                        size_q     <= req_size;
                        write_q    <= req_write;
                        unsigned_q <= req_unsigned;
                        data_q     <= req_wdata;
                        if (req_err) begin
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (write_q) begin
                        data_q <= merged;
                    end else begin
                        resp_rdata_q <= ld_data;
                        resp_err_q   <= 1'b0;
                    end
                end
                ST_WR: begin
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Write enable is gated by rst so a reset landing in WR never commits.
    assign mem_we      = (state_q == ST_WR) & ~rst;
    assign mem_wdata   = data_q;
    assign mem_addr    = addr_q[ADDR_WIDTH+1:2];
    assign resp_valid  = (state_q == ST_RESP);
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front-end between the MIPS datapath's MEM stage and the word-organised data RAM. Accepts byte-addressed load/store requests of byte, halfword or word size, converts them to word-indexed RAM accesses, and sign- or zero-extends sub-word loads. Performs sub-word stores as read-modify-write. Flags misaligned and out-of-range accesses without touching memory.

## Interface
- `ADDR_WIDTH`, 13: width of the word index driven to the RAM.
- `DEPTH`, 4401: number of valid RAM words; word index `>= DEPTH` is out of range.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; a request is accepted on an edge where `req_valid & req_ready`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word; 11 is illegal.
- `req_unsigned` in 1: zero-extend loads (LBU/LHU); ignored for stores and words.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned, illegal size, or out of range; valid with `resp_valid`.
- `mem_addr` out ADDR_WIDTH: word index, `req_addr[ADDR_WIDTH+1:2]` of the latched request.
- `mem_wdata` out 32: full word to write.
- `mem_we` out 1: RAM write enable; RAM writes on the rising edge where it is high.
- `mem_rdata` in 32: RAM read data, valid the cycle after `mem_addr` is presented (one-cycle registered read).

## Operation
- Request fields are latched on accept; inputs are ignored outside IDLE.
- States: IDLE, RD, RD_DATA, WR, RESP.
- **Accept, transitions from IDLE:**
  - error → RESP
  - word store → WR
  - load or sub-word store → RD
- **Error conditions:** the request goes to RESP with `resp_err=1` and no memory access when any of these hold:
  - halfword with `addr[0]≠0`
  - word with `addr[1:0]≠0`
  - size 11
  - `addr[31:2] >= DEPTH`
- **RD:** drive `mem_addr`, then → RD_DATA.
- **RD_DATA:** `mem_rdata` is valid.
  - Load: register the extracted, extended result, → RESP.
  - Sub-word store: register the merged word, → WR.
- **WR:** `mem_we=1` with `mem_wdata` (the merged word, or `req_wdata` for word stores), → RESP.
- **RESP:** `resp_valid=1` for exactly one cycle, → IDLE.
- **Byte order is big-endian:**
  - Byte offset 0 is bits [31:24], offset 3 is bits [7:0].
  - Half offset 0 is [31:16], offset 2 is [15:0].
- **Sub-word store merge:** only the addressed lane is replaced with `req_wdata[7:0]` or `req_wdata[15:0]`; all other bits keep their read value.
- **Load extension:** signed loads replicate the lane MSB into the upper bits; unsigned loads fill with zeros. Word loads pass through.
- **Reset:**
  - Any state → IDLE.
  - `resp_valid=0`, `resp_err=0`, `resp_rdata=0`, internal data registers 0.
  - `req_ready=1` from the first cycle after reset.
  - `mem_we` is gated by `rst`, so no RAM write occurs in a cycle where `rst` is high, including in WR.
  - An aborted operation produces no response.

## Timing
- Accept cycle = cycle 0. `resp_valid` is high in:
  - load: cycle 3
  - word store: cycle 2
  - sub-word store: cycle 4
  - error: cycle 1
- Next accept is possible in the cycle after RESP. Throughput is one request per (latency+1) cycles; there is no pipelining.
- `mem_we` is high in exactly one cycle per successful store and never for loads or errors.
- `mem_addr` is held stable from RD (or WR) through RESP.
- `resp_rdata` and `resp_err` are registered and held until the next response or reset. They are only meaningful with `resp_valid`.

## Structure
- Package `mem_access_pkg`:
  - Size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`
  - State enum
  - `DEPTH` default
- Sub-module `ld_align` (combinational) performs lane extraction plus sign/zero extension from `(word, offset, size, unsigned)`. It is reused by the datapath's forwarding logic. The store merge stays inline.

## Test plan
- After reset, with RAM word 0 = `0x8034_56F0`:
  - LB addr 0 → `resp_rdata=0xFFFF_FF80` at cycle 3.
  - LBU addr 0 → `0x0000_0080`.
  - LH addr 2 → `0x0000_56F0`.
- SB `wdata=0xAB` to addr 5 with word 1 = `0x1122_3344` → `mem_we` only in cycle 3 with `mem_wdata=0x11AB_3344`; `resp_valid` in cycle 4.
- SW `0xDEAD_BEEF` to addr 8 → `mem_we` in cycle 1, `resp_valid` in cycle 2; subsequent LW addr 8 returns `0xDEAD_BEEF`.
- The following each give `resp_err=1` in cycle 1 with `mem_we` never asserted:
  - LH addr 3
  - LW addr 6
  - size 11
  - LW addr `4*4401`
- Assert `rst` while in WR of an SH → no RAM write, no `resp_valid`, `req_ready=1` the next cycle; a following LW returns the old word.
- Hold `req_valid` high continuously with changing fields → only requests sampled while `req_ready=1` are executed; exactly one `resp_valid` per accept.
